regfile_scb: RTL and testbench

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_scb_if.sv | 32 +++
 rtl/regfile_scb.sv | 127 ++++++++++++
 tb/tb_regfile_scb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scb_if.sv
// Bus interface for regfile_scb: write port, two read ports with busy flags,
// the reservation port and the clear handshake.
//   slave  : the register file side (drives ready/rdata/busy)
//   master : the requester side (drives clear/write/read/reserve)
interface regfile_scb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              clear_i;
  logic              ready_o;
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata1_o;
  logic [DATA_W-1:0] rdata2_o;
  logic              resv_i;
  logic [ADDR_W-1:0] resv_addr_i;
  logic              busy1_o;
  logic              busy2_o;

  modport slave (
    input  clear_i, we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, resv_i, resv_addr_i,
    output ready_o, rdata1_o, rdata2_o, busy1_o, busy2_o
  );

  modport master (
    output clear_i, we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, resv_i, resv_addr_i,
    input  ready_o, rdata1_o, rdata2_o, busy1_o, busy2_o
  );
endinterface

// File: rtl/regfile_scb.sv
// regfile_scb: register file with a per-entry pending (scoreboard) bit and a
// sequential wipe engine.
//   clk_i  : clock, all state updates on rising edge
//   rst_i  : asynchronous active-high reset, forces a fresh wipe
//   bus    : regfile_scb_if.slave
//            clear_i/ready_o          wipe request / file usable
//            we_i/waddr_i/wdata_i     write port (also retires a reservation)
//            raddrN_i/rdataN_o        two asynchronous read ports
//            resv_i/resv_addr_i       mark an entry as awaiting a result
//            busyN_o                  pending bit of raddrN_i (registered, not bypassed)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// onto a matching read port.
module regfile_scb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  regfile_scb_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [Depth-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic idle;
  logic zero_en;
  logic wr_en;
  logic resv_en;

  assign idle    = (state_q == StIdle);
  assign zero_en = (ZERO_REG != 0);
  // Entry 0 is never written nor reserved when hardwired to zero.
  assign wr_en   = idle && bus.we_i && !(zero_en && (bus.waddr_i == '0));
  assign resv_en = bus.resv_i && !(zero_en && (bus.resv_addr_i == '0));

  // Next-state: wipe counter, FSM and pending bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.clear_i) begin
          state_d = StClear;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          // Retire first so a same-address reservation wins.
          if (bus.we_i) begin
            pend_d[bus.waddr_i] = 1'b0;
          end
          if (resv_en) begin
            pend_d[bus.resv_addr_i] = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StClear;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage has no reset; the wipe engine defines its contents.
  always_ff @(posedge clk_i) begin
    if (!idle) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[bus.waddr_i] <= bus.wdata_i;
    end
  end

  // Read ports: zero while wiping or for the hardwired entry.
  always_comb begin
    bus.rdata1_o = '0;
    bus.rdata2_o = '0;
    if (idle) begin
      if (!(zero_en && (bus.raddr1_i == '0))) begin
        bus.rdata1_o = mem_q[bus.raddr1_i];
      end
      if (!(zero_en && (bus.raddr2_i == '0))) begin
        bus.rdata2_o = mem_q[bus.raddr2_i];
      end
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes the hardwired entry.
      if (wr_en && (bus.waddr_i == bus.raddr1_i)) begin
        bus.rdata1_o = bus.wdata_i;
      end
      if (wr_en && (bus.waddr_i == bus.raddr2_i)) begin
        bus.rdata2_o = bus.wdata_i;
      end
`else
      // Writes become visible only after the clock edge.
`endif
    end
  end

  assign bus.busy1_o = idle && pend_q[bus.raddr1_i] && !(zero_en && (bus.raddr1_i == '0));
  assign bus.busy2_o = idle && pend_q[bus.raddr2_i] && !(zero_en && (bus.raddr2_i == '0));
  assign bus.ready_o = idle;

endmodule

// File: tb/tb_regfile_scb.sv
// Self-checking bench for regfile_scb: a behavioural model (remaining wipe
// cycles, entry array, pending array) predicts every output each cycle, and a
// few directed scenarios pin literal values.
module tb_regfile_scb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_scb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_scb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(ZR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int               m_left = DEPTH;   // wipe cycles still to run

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= DEPTH;
      m_pend <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      end
    end else if (bus.clear_i) begin
      m_left <= DEPTH;
      m_pend <= '0;
    end else begin
      if (bus.we_i && !(ZR != 0 && bus.waddr_i == 0)) m_mem[bus.waddr_i] <= bus.wdata_i;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.resv_i && bus.resv_addr_i == i) m_pend[i] <= 1'b1;
        else if (bus.we_i && bus.waddr_i == i) m_pend[i] <= 1'b0;
      end
    end
  end

  function automatic logic exp_ready();
    return !rst && (m_left == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    if (rst || m_left != 0) return '0;
    if (ZR != 0 && a == 0) return '0;
    if (BYP && bus.we_i && bus.waddr_i == a) return bus.wdata_i;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    if (rst || m_left != 0) return 1'b0;
    if (ZR != 0 && a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  // ---------------- compare process ----------------
  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk_en   = 1'b0;
  int    pin_kind = 0;   // 1 rdata1, 2 rdata2, 3 busy1, 4 ready, 5 busy2
  logic [31:0] pin_val = '0;
  string pin_name = "";

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.ready_o), 32'(exp_ready()));
      check("rdata1", bus.rdata1_o, exp_rd(bus.raddr1_i));
      check("rdata2", bus.rdata2_o, exp_rd(bus.raddr2_i));
      check("busy1", 32'(bus.busy1_o), 32'(exp_busy(bus.raddr1_i)));
      check("busy2", 32'(bus.busy2_o), 32'(exp_busy(bus.raddr2_i)));
      case (pin_kind)
        1: check(pin_name, bus.rdata1_o, pin_val);
        2: check(pin_name, bus.rdata2_o, pin_val);
        3: check(pin_name, 32'(bus.busy1_o), pin_val);
        4: check(pin_name, 32'(bus.ready_o), pin_val);
        5: check(pin_name, 32'(bus.busy2_o), pin_val);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    pin_kind = 0;
  endtask

  task automatic pin(int k, logic [31:0] v, string n);
    pin_kind = k;
    pin_val  = v;
    pin_name = n;
  endtask

  task automatic idle_in();
    bus.we_i    = 1'b0;
    bus.resv_i  = 1'b0;
    bus.clear_i = 1'b0;
  endtask

  function automatic logic [AW-1:0] ra();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    idle_in();
    bus.waddr_i     = '0;
    bus.wdata_i     = '0;
    bus.raddr1_i    = '0;
    bus.raddr2_i    = '0;
    bus.resv_addr_i = '0;
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    pin(4, 0, "ready_in_reset");
    cyc();
    rst = 1'b0;

    // Reset release: exactly DEPTH wipe cycles.
    repeat (DEPTH - 1) cyc();
    pin(4, 0, "ready_low_last_wipe_cycle");
    cyc();
    pin(4, 1, "ready_high_after_wipe");
    cyc();
    for (int a = 0; a < DEPTH; a++) begin
      bus.raddr1_i = AW'(a);
      bus.raddr2_i = AW'(DEPTH - 1 - a);
      pin(1, 0, "wiped_entry_zero");
      cyc();
    end

    // Same-cycle write/read of x7.
    bus.we_i = 1'b1; bus.waddr_i = 7; bus.wdata_i = 32'hA5A5_A5A5; bus.raddr1_i = 7;
    pin(1, BYP ? 32'hA5A5_A5A5 : 32'h0, "x7_same_cycle");
    cyc();
    bus.we_i = 1'b0;
    pin(1, 32'hA5A5_A5A5, "x7_after_edge");
    cyc();

    // Write x5, read on both ports; write to x0 is dropped.
    bus.we_i = 1'b1; bus.waddr_i = 5; bus.wdata_i = 32'hDEAD_BEEF;
    bus.raddr1_i = 5; bus.raddr2_i = 5;
    cyc();
    bus.we_i = 1'b0;
    pin(1, 32'hDEAD_BEEF, "x5_port1");
    cyc();
    pin(2, 32'hDEAD_BEEF, "x5_port2");
    cyc();
    bus.we_i = 1'b1; bus.waddr_i = 0; bus.wdata_i = 32'h1234; bus.raddr1_i = 0;
    cyc();
    bus.we_i = 1'b0;
    pin(1, 0, "x0_reads_zero");
    cyc();

    // Scoreboard on x9.
    bus.resv_i = 1'b1; bus.resv_addr_i = 9; bus.raddr1_i = 9;
    pin(3, 0, "busy9_not_bypassed");
    cyc();
    bus.resv_i = 1'b0;
    pin(3, 1, "busy9_set");
    cyc();
    bus.we_i = 1'b1; bus.waddr_i = 9; bus.wdata_i = 32'h77; bus.resv_i = 1'b1;
    cyc();
    idle_in();
    pin(3, 1, "busy9_resv_wins");
    cyc();
    bus.we_i = 1'b1; bus.waddr_i = 9;
    cyc();
    bus.we_i = 1'b0;
    pin(3, 0, "busy9_retired");
    cyc();

    // Clear with x3 holding data and x4 pending.
    bus.we_i = 1'b1; bus.waddr_i = 3; bus.wdata_i = 32'h55;
    bus.resv_i = 1'b1; bus.resv_addr_i = 4;
    cyc();
    idle_in();
    bus.raddr1_i = 3; bus.raddr2_i = 4;
    pin(1, 32'h55, "x3_before_clear");
    bus.clear_i = 1'b1;
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      bus.clear_i = 1'(i & 1);
      bus.we_i = 1'b1; bus.waddr_i = 3; bus.wdata_i = $urandom;
      bus.resv_i = 1'b1; bus.resv_addr_i = 4;
      pin(4, 0, "ready_low_during_clear");
      cyc();
    end
    idle_in();
    pin(1, 0, "x3_wiped");
    cyc();
    pin(5, 0, "x4_not_busy_after_clear");
    cyc();

    // Reset in the middle of a wipe restarts it.
    bus.clear_i = 1'b1;
    cyc();
    bus.clear_i = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    pin(4, 0, "ready_low_in_rst");
    cyc();
    cyc();
    rst = 1'b0;
    repeat (DEPTH - 1) cyc();
    pin(4, 0, "ready_low_31_after_rst");
    cyc();
    pin(4, 1, "ready_rises_32_after_rst");
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.we_i        = 1'($urandom_range(0, 1));
      bus.waddr_i     = ra();
      bus.wdata_i     = $urandom;
      bus.raddr1_i    = ra();
      bus.raddr2_i    = ($urandom_range(0, 3) == 0) ? bus.raddr1_i : ra();
      bus.resv_i      = 1'($urandom_range(0, 1));
      bus.resv_addr_i = ra();
      bus.clear_i     = ($urandom_range(0, 299) == 0);
      rst             = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0;
    idle_in();
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
